alu_seq_nbit: RTL
=================

Name: alu_seq_nbit

Overview:
- Parametrised, clocked successor to the lab's 4-bit combinational ALU.
- Latches operands on a start handshake and computes add, sub, logic and shift ops in one cycle.
- Multiplies with an iterative shift-add datapath over WIDTH cycles.
- Presents registered result and NZCV flags with a done pulse; sits between switch/button input logic and the seven-segment display path.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A; sampled only when a start is accepted.
- b  input  WIDTH  operand B; sampled only when a start is accepted.
- op  input  4  opcode; sampled only when a start is accepted.
- start  input  1  request; accepted only in IDLE.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result and flags update.
- result  output  WIDTH  registered result; held until the next done.
- NFlag, ZFlag, CFlag, VFlag  output  1 each  registered flags; held with result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, all flags=0. Internal operand, product and counter registers cleared.
- Reset mid-operation aborts the operation, gives no done pulse and discards the operands.
- Reset has priority over start.
- States: IDLE, CALC, MUL.
- IDLE, start=1 on edge E0: latch a, b, op; busy=1.
  - op=0010 -> MUL, counter=0, accumulator=0.
  - Any other op -> CALC.
- CALC, edge E1: register result and flags; done=1 for the cycle after E1; busy=0; -> IDLE.
- MUL:
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator; shift both; counter+1.
  - On the WIDTH-th MUL edge: register result and flags, done=1, busy=0, -> IDLE.
  - Latency from E0 to the edge that raises done is WIDTH+1 edges.
- start while busy=1 is ignored; no queuing.
- start is sampled on the edge after done rises and is accepted if high, since state is IDLE by then.
- Operand or op changes during busy have no effect.
- done is low every cycle except the single pulse cycle.
- Opcodes:
  - 0000 add.
  - 0001 sub (a-b).
  - 0010 mul.
  - 0011 and.
  - 0100 or.
  - 0101 xor.
  - 0110 shl by 1.
  - 0111 shr logical by 1.
  - Others: result=0 and all flags 0, still completing through CALC with a done pulse.
- Width rules: result is truncated to WIDTH bits; mul keeps the low WIDTH bits of the 2*WIDTH product.
- ZFlag = (result==0) for all defined ops.
- NFlag = result[WIDTH-1] for add, sub, logic and shift ops; NFlag=0 for mul.
- CFlag:
  - add: carry out of the MSB.
  - sub: borrow (a<b unsigned).
  - shl: a[WIDTH-1].
  - shr: a[0].
  - Otherwise 0.
- VFlag:
  - add/sub: two's-complement signed overflow.
  - mul: upper WIDTH product bits nonzero.
  - Otherwise 0.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: op=1000 is unsigned restoring division a/b, executed in a DIV state of WIDTH iterations, same latency as mul. result=quotient; ZFlag=(quotient==0); NFlag=0; CFlag=(remainder!=0).
  - Divide by zero: result=all ones, VFlag=1, otherwise VFlag=0, same latency.
- Undefined: no DIV state exists; op=1000 behaves as an undefined opcode (result 0, flags 0, CALC latency).

Test Plan:
- WIDTH=4, a=0111, b=0001, op=0000, start pulse -> done 2 edges later; result=1000, N=1, Z=0, C=0, V=1.
- WIDTH=4, a=0011, b=0101, op=0001 -> result=1110, N=1, C=1 (borrow), V=0, Z=0.
- WIDTH=4, a=0101, b=0011, op=0010 -> busy for 5 edges, done on the 5th edge; result=1111, V=0. Then a=0100, b=0100 -> result=0000, Z=1, V=1.
- WIDTH=4: start mul, re-pulse start with op=0000 while busy -> ignored, one done only, mul result. Assert rst on the 2nd MUL edge -> outputs all 0, no done, next start accepted normally.
- WIDTH=8, a=10000001, op=0110 -> result=00000010, C=1. op=0111 -> result=01000000, C=1. op=1111 -> result=0, flags 0, done pulses.
- ALU_DIV_EN, WIDTH=4: a=1101, b=0011, op=1000 -> result=0100, C=1 after 5 edges. b=0000 -> result=1111, V=1.

Source files
------------

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: one-cycle arithmetic/logic ops and an iterative shift-add multiply.
// Optional unsigned restoring divider (opcode 1000) is enabled by defining ALU_DIV_EN.
module alu_seq_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             NFlag,
  output logic             ZFlag,
  output logic             CFlag,
  output logic             VFlag
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    MUL
`ifdef ALU_DIV_EN
    , DIV
`endif
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1000;
`endif
  localparam int MSB = WIDTH - 1;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [3:0]         op_reg;
  logic [2*WIDTH-1:0] mcand, acc, acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [4:0]         cnt;
  logic               last_iter;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   calc_res;
  logic               calc_n, calc_z, calc_c, calc_v;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]   quo, rem, quo_next, rem_next;
  logic [WIDTH:0]     trial;
  logic               trial_ge;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) state_next = MUL;
`ifdef ALU_DIV_EN
          else if (op == OP_DIV) state_next = DIV;
`endif
          else state_next = CALC;
        end
      end
      CALC: state_next = IDLE;
      MUL:  if (last_iter) state_next = IDLE;
`ifdef ALU_DIV_EN
      DIV:  if (last_iter) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops; undefined opcodes leave every flag low, including Z.
  always_comb begin
    ext       = '0;
    calc_res  = '0;
    calc_c    = 1'b0;
    calc_v    = 1'b0;
    last_iter = (cnt == 5'(WIDTH - 1));
    acc_sum   = mplier[0] ? (acc + mcand) : acc;
    case (op_reg)
      OP_ADD: begin
        ext      = {1'b0, a_reg} + {1'b0, b_reg};
        calc_res = ext[WIDTH-1:0];
        calc_c   = ext[WIDTH];
        calc_v   = (a_reg[MSB] == b_reg[MSB]) && (calc_res[MSB] != a_reg[MSB]);
      end
      OP_SUB: begin
        ext      = {1'b0, a_reg} - {1'b0, b_reg};
        calc_res = ext[WIDTH-1:0];
        calc_c   = (a_reg < b_reg);
        calc_v   = (a_reg[MSB] != b_reg[MSB]) && (calc_res[MSB] != a_reg[MSB]);
      end
      OP_AND: calc_res = a_reg & b_reg;
      OP_OR:  calc_res = a_reg | b_reg;
      OP_XOR: calc_res = a_reg ^ b_reg;
      OP_SHL: begin
        calc_res = a_reg << 1;
        calc_c   = a_reg[MSB];
      end
      OP_SHR: begin
        calc_res = a_reg >> 1;
        calc_c   = a_reg[0];
      end
      default: calc_res = '0;
    endcase
    calc_n = 1'b0;
    calc_z = 1'b0;
    if (op_reg <= OP_SHR && op_reg != OP_MUL) begin
      calc_n = calc_res[MSB];
      calc_z = (calc_res == '0);
    end
  end

`ifdef ALU_DIV_EN
  // One restoring step: shift the next dividend bit into the remainder and subtract if it fits.
  always_comb begin
    trial    = {rem, quo[MSB]};
    trial_ge = (trial >= {1'b0, b_reg});
    rem_next = trial_ge ? WIDTH'(trial - {1'b0, b_reg}) : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], trial_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      NFlag  <= 1'b0;
      ZFlag  <= 1'b0;
      CFlag  <= 1'b0;
      VFlag  <= 1'b0;
`ifdef ALU_DIV_EN
      quo    <= '0;
      rem    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
`ifdef ALU_DIV_EN
            quo    <= a;
            rem    <= '0;
`endif
          end
        end
        CALC: begin
          result <= calc_res;
          NFlag  <= calc_n;
          ZFlag  <= calc_z;
          CFlag  <= calc_c;
          VFlag  <= calc_v;
          done   <= 1'b1;
        end
        MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_iter) begin
            result <= acc_sum[WIDTH-1:0];
            NFlag  <= 1'b0;
            ZFlag  <= (acc_sum[WIDTH-1:0] == '0);
            CFlag  <= 1'b0;
            VFlag  <= |acc_sum[2*WIDTH-1:WIDTH];
            done   <= 1'b1;
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (last_iter) begin
            result <= quo_next;
            NFlag  <= 1'b0;
            ZFlag  <= (quo_next == '0);
            CFlag  <= (b_reg != '0) && (rem_next != '0);
            VFlag  <= (b_reg == '0);
            done   <= 1'b1;
          end
        end
`endif
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
